// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared IEEE-754 single field constants and ftoi stage-1 record
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } s1_t;

  function automatic s1_t unpack_f32(input logic [31:0] x);
    s1_t r;
    r.sign    = x[EXP_W+MAN_W];
    r.exp     = x[EXP_W+MAN_W-1:MAN_W];
    r.is_zero = (r.exp == '0);
    r.man     = {!r.is_zero, x[MAN_W-1:0]};
    r.is_inf  = (&r.exp) && (x[MAN_W-1:0] == '0);
    r.is_nan  = (&r.exp) && (x[MAN_W-1:0] != '0);
    return r;
  endfunction
endpackage

// File: rtl/ftoi_round.sv
// rtl/ftoi_round.sv - stage-2 shift, round-to-nearest, saturate and sign-apply
// FTOI_FLAGS_EN adds the ovf output.
module ftoi_round
  import fpu_pkg::*;
#(
  parameter int TIE_AWAY = 1
) (
  input  s1_t         op,
  output logic [31:0] res
`ifdef FTOI_FLAGS_EN
  ,
  output logic        ovf
`endif
);
  localparam logic [EXP_W-1:0] EXP_HALF = EXP_W'(BIAS - 1);
  localparam logic [EXP_W-1:0] EXP_OVF  = EXP_W'(BIAS + 31);
  localparam logic [MAN_W:0]   MIN_MAN  = {1'b1, {MAN_W{1'b0}}};

  logic [EXP_W-1:0] sh;
  logic [63:0]      fx;
  logic [31:0]      ip;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic [32:0]      mag;
  logic             in_range;
  logic             sat;

  // fx holds the significand as 32.32 fixed point; shift is 1..32 inside in_range
  always_comb begin
    sh       = EXP_OVF - op.exp;
    fx       = {op.man, 40'd0} >> sh;
    ip       = fx[63:32];
    guard    = fx[31];
    sticky   = |fx[30:0];
    inc      = guard && (sticky || (TIE_AWAY != 0) || ip[0]);
    mag      = {1'b0, ip} + 33'(inc);
    in_range = !op.is_zero && (op.exp >= EXP_HALF) && (op.exp < EXP_OVF);
    sat      = op.is_nan || op.is_inf || (op.exp >= EXP_OVF)
               || (in_range && (mag > {1'b0, INT_MAX}));
    res      = '0;
    if (op.is_nan) begin
      res = INT_MAX;
    end else if (sat) begin
      res = op.sign ? INT_MIN : INT_MAX;
    end else if (in_range) begin
      res = op.sign ? -mag[31:0] : mag[31:0];
    end
  end

`ifdef FTOI_FLAGS_EN
  logic exact_min;

  // exactly -2^31 is representable, so it saturates without flagging
  always_comb begin
    exact_min = op.sign && (((op.exp == EXP_OVF) && (op.man == MIN_MAN))
                            || (in_range && (mag == {1'b0, INT_MIN})));
    ovf       = sat && !exact_min;
  end
`endif
endmodule

// File: rtl/ftoi.sv
// rtl/ftoi.sv - IEEE-754 single to int32 converter, 2-stage valid/ready pipeline
// FTOI_FLAGS_EN adds the ovf output carried alongside d.
module ftoi
  import fpu_pkg::*;
#(
  parameter int TIE_AWAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d
`ifdef FTOI_FLAGS_EN
  ,
  output logic        ovf
`endif
);
  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  logic        s1_adv, s2_adv;
  s1_t         s1_q, s1_d;
  logic [31:0] d_q, d_d;
  logic [31:0] round_res;

`ifdef FTOI_FLAGS_EN
  logic ovf_q, ovf_d;
  logic round_ovf;
`endif

  ftoi_round #(
    .TIE_AWAY(TIE_AWAY)
  ) u_round (
    .op (s1_q),
    .res(round_res)
`ifdef FTOI_FLAGS_EN
    ,
    .ovf(round_ovf)
`endif
  );

  always_comb begin
    s2_adv = !v2_q || d_ready;
    s1_adv = !v1_q || s2_adv;
    v1_d   = s1_adv ? s_valid : v1_q;
    v2_d   = s2_adv ? v1_q : v2_q;
    s1_d   = (s1_adv && s_valid) ? unpack_f32(s) : s1_q;
    d_d    = (s2_adv && v1_q) ? round_res : d_q;
  end

`ifdef FTOI_FLAGS_EN
  always_comb begin
    ovf_d = (s2_adv && v1_q) ? round_ovf : ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      d_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      d_q  <= d_d;
    end
  end

  // stage-1 payload is qualified by v1_q, so it needs no reset
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign s_ready = s1_adv;
  assign d_valid = v2_q;
  assign d       = d_q;
endmodule

// File: tb/tb_ftoi.sv
// tb/tb_ftoi.sv - self-checking bench for ftoi (TIE_AWAY=1 and TIE_AWAY=0 instances)
module tb_ftoi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        d_ready = 1'b0;
  logic [31:0] s = '0;
  logic        s_ready, d_valid, s_ready_e, d_valid_e;
  logic [31:0] d, d_e;
`ifdef FTOI_FLAGS_EN
  logic        ovf, ovf_e;
`endif

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] w;
    int          age;
  } ent_t;
  ent_t        q[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic        acc = 1'b0;
  logic        dlv = 1'b0;
  bit          mon_en = 1'b0;
  bit          rnd_done = 1'b0;

  always #5 clk = ~clk;

  ftoi #(.TIE_AWAY(1)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s(s),
    .d_valid(d_valid), .d_ready(d_ready), .d(d)
`ifdef FTOI_FLAGS_EN
    , .ovf(ovf)
`endif
  );

  ftoi #(.TIE_AWAY(0)) dut_e (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_e), .s(s),
    .d_valid(d_valid_e), .d_ready(d_ready), .d(d_e)
`ifdef FTOI_FLAGS_EN
    , .ovf(ovf_e)
`endif
  );

  // Value-level reference: {ovf, result}
  function automatic logic [32:0] model(input logic [31:0] x, input int tie);
    real         a, fl, fr;
    int          e;
    longint      iv;
    logic [31:0] r;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 23'd0) return {1'b1, 32'h7FFF_FFFF};
      return x[31] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    end
    if (x[30:23] == 8'h00) return 33'd0;
    a = real'(int'({1'b1, x[22:0]}));
    e = int'(x[30:23]) - 150;
    while (e > 0) begin a = a * 2.0; e--; end
    while (e < 0) begin a = a / 2.0; e++; end
    fl = $floor(a);
    fr = a - fl;
    if (fr > 0.5 || (fr == 0.5 && (tie != 0 || $floor(fl / 2.0) * 2.0 != fl))) fl = fl + 1.0;
    if (!x[31] && fl >= 2147483648.0) return {1'b1, 32'h7FFF_FFFF};
    if (x[31] && fl > 2147483648.0) return {1'b1, 32'h8000_0000};
    if (x[31] && fl == 2147483648.0) return {1'b0, 32'h8000_0000};
    iv = longint'(fl);
    r = iv[31:0];
    if (x[31]) r = -r;
    return {1'b0, r};
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %08h required %08h", name, act, req);
  endtask

  task automatic pin(input logic [31:0] w, input int tie, input logic [32:0] req,
                     input string name);
    logic [32:0] r;
    r = model(w, tie);
    check(r == req, name, r[31:0], req[31:0]);
  endtask

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    logic [32:0] m1, m0;
    bit          exp_v;
    acc = 1'b0;
    dlv = 1'b0;
    if (!rst && mon_en) begin
      exp_v = (q.size() > 0) && (q[0].age >= 1);
      check(s_ready == !(q.size() == 2 && !d_ready), "s_ready", 32'(s_ready),
            32'(!(q.size() == 2 && !d_ready)));
      check(d_valid == exp_v, "d_valid", 32'(d_valid), 32'(exp_v));
      check(d_valid_e == exp_v, "d_valid_te", 32'(d_valid_e), 32'(exp_v));
      if (hold_v) check(d == hold_d, "stall_hold", d, hold_d);
      if (exp_v && d_valid && d_ready) begin
        m1 = model(q[0].w, 1);
        m0 = model(q[0].w, 0);
        check(d == m1[31:0], "d_tie_away", d, m1[31:0]);
        check(d_e == m0[31:0], "d_tie_even", d_e, m0[31:0]);
`ifdef FTOI_FLAGS_EN
        check(ovf == m1[32], "ovf", 32'(ovf), 32'(m1[32]));
        check(ovf_e == m0[32], "ovf_te", 32'(ovf_e), 32'(m0[32]));
`endif
      end
      hold_v = d_valid && !d_ready;
      hold_d = d;
      acc = s_valid && s_ready;
      dlv = d_valid && d_ready;
    end
  end

  always @(posedge clk) begin
    if (!rst && mon_en) begin
      if (dlv && q.size() > 0) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back('{w: s, age: 0});
    end
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    s = w;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 100) begin
        check(1'b0, "send_timeout", 32'(n), 32'd100);
        break;
      end
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(q.size() == 0, "drain", 32'(q.size()), 32'd0);
  endtask

  logic [31:0] vecs[16] = '{32'h3FC00000, 32'hBFC00000, 32'h40200000, 32'h3EFFFFFF,
                            32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'h3F000000,
                            32'hBF000000, 32'h80000000, 32'h00000001, 32'h7F800000,
                            32'hFF800000, 32'hCF000001, 32'h40600000, 32'h4B7FFFFF};

  initial begin
    logic [31:0] w;
    #1;
    check(d_valid == 1'b0, "rst_d_valid", 32'(d_valid), 32'd0);
    check(d == 32'd0, "rst_d", d, 32'd0);
`ifdef FTOI_FLAGS_EN
    check(ovf == 1'b0, "rst_ovf", 32'(ovf), 32'd0);
`endif

    pin(32'h3FC00000, 1, {1'b0, 32'h00000002}, "pin_1p5");
    pin(32'hBFC00000, 1, {1'b0, 32'hFFFFFFFE}, "pin_m1p5");
    pin(32'h40200000, 1, {1'b0, 32'h00000003}, "pin_2p5_away");
    pin(32'h40200000, 0, {1'b0, 32'h00000002}, "pin_2p5_even");
    pin(32'h3EFFFFFF, 1, {1'b0, 32'h00000000}, "pin_below_half");
    pin(32'h3F000000, 1, {1'b0, 32'h00000001}, "pin_half_away");
    pin(32'h3F000000, 0, {1'b0, 32'h00000000}, "pin_half_even");
    pin(32'h4F000000, 1, {1'b1, 32'h7FFFFFFF}, "pin_pos_ovf");
    pin(32'hCF000000, 1, {1'b0, 32'h80000000}, "pin_int_min");
    pin(32'h7FC00000, 1, {1'b1, 32'h7FFFFFFF}, "pin_nan");
    pin(32'hFF800000, 1, {1'b1, 32'h80000000}, "pin_neg_inf");

    d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check(s_ready == 1'b1, "s_ready_after_rst", 32'(s_ready), 32'd1);

    // first-result latency
    @(posedge clk);
    #1 s = 32'h3FC00000;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk);
    check(d_valid == 1'b0, "latency_c1", 32'(d_valid), 32'd0);
    @(negedge clk);
    check(d_valid == 1'b1, "latency_c2", 32'(d_valid), 32'd1);
    check(d == 32'h2, "latency_data", d, 32'h2);
    wait_empty();

    // back-to-back directed stream at full rate
    for (int i = 0; i < 16; i++) send(vecs[i]);
    wait_empty();

    // random backpressure
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          w = $urandom;
          w[30:23] = 8'($urandom_range(120, 160));
          send(w);
        end
        wait_empty();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 d_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    d_ready = 1'b1;

    // reset with two words in flight
    d_ready = 1'b0;
    send(32'h40200000);
    send(32'hBFC00000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check(d_valid == 1'b0, "midrst_d_valid", 32'(d_valid), 32'd0);
    check(d_valid_e == 1'b0, "midrst_d_valid_te", 32'(d_valid_e), 32'd0);
    check(d == 32'd0, "midrst_d", d, 32'd0);
    q.delete();
    hold_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    d_ready = 1'b1;
    @(negedge clk);
    check(s_ready == 1'b1, "s_ready_post_midrst", 32'(s_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check(d_valid == 1'b0, "no_stale", 32'(d_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ftoi.md
FTOI -- requirements
Module: ftoi

Interface
REQ-001 SHALL have parameter: TIE_AWAY, default 1, tie rounding (1 = ties away from zero, 0 = ties to even).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: s_valid  input  1  input word valid.
REQ-005 SHALL have port: s_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port: s  input  32  IEEE-754 single operand.
REQ-007 SHALL have port: d_valid  output  1  result valid.
REQ-008 SHALL have port: d_ready  input  1  downstream accepts result.
REQ-009 SHALL have port: d  output  32  two's-complement signed integer result.
REQ-010 SHALL have port (only with FTOI_FLAGS_EN): ovf  output  1  result saturated or operand NaN/Inf; qualified by d_valid.

Function
REQ-011 SHALL accept a word on a cycle with s_valid && s_ready, and deliver it on a cycle with d_valid && d_ready.
REQ-012 SHALL be a 2-stage pipeline: stage 1 registers sign, exponent, 24-bit significand with hidden bit, and special-case flags; stage 2 registers shifted, rounded, saturated, sign-applied result.
REQ-013 SHALL have minimum latency 2 cycles from acceptance to d_valid, with throughput 1 word/cycle when d_ready stays high.
REQ-014 SHALL advance stage 2 when it is empty or d_ready=1, advance stage 1 when it is empty or stage 2 advances, and drive s_ready = stage-1 advance condition (combinational from d_ready allowed).
REQ-015 SHALL hold d and d_valid stable while d_valid && !d_ready, and SHALL NOT drop or duplicate words.
REQ-016 SHALL round to nearest, with ties as per TIE_AWAY, using guard and sticky bits from the full significand.
REQ-017 SHALL return 0 for exponent field 0 (zero and denormals), with ovf=0.
REQ-018 SHALL return 0 for |x| < 0.5, and +/-1 at exactly 0.5 when TIE_AWAY=1 (0 when TIE_AWAY=0).
REQ-019 SHALL return 0x7FFFFFFF for positive overflow (rounded magnitude >= 2^31), ovf=1.
REQ-020 SHALL return 0x80000000 for negative overflow (rounded magnitude > 2^31), ovf=1.
REQ-021 SHALL return 0x80000000 for exactly -2^31, ovf=0.
REQ-022 SHALL return 0x7FFFFFFF for NaN, with ovf=1.
REQ-023 SHALL return 0x7FFFFFFF for +Inf and 0x80000000 for -Inf, with ovf=1.
REQ-024 SHALL take the sign from s[31] and produce the negated magnitude for negative inputs; -0.0 -> 0.

Reset
REQ-025 SHALL, while rst=1, clear both stage-valid bits immediately, and drive d_valid=0, d=0, ovf=0.
REQ-026 SHALL drive s_ready=1 in the first cycle after rst deasserts.
REQ-027 SHALL discard in-flight words on reset mid-operation, and SHALL NOT emit them afterwards.
REQ-028 SHALL leave data registers other than d free of reset.

Configuration
REQ-029 SHALL, with FTOI_FLAGS_EN defined, provide port ovf and carry the flag through both stages.
REQ-030 SHALL, without FTOI_FLAGS_EN, omit port ovf and its registers, with d values unchanged.

Structure
REQ-031 SHALL place in shared package fpu_pkg: field-width constants (EXP_W=8, MAN_W=23, BIAS=127), INT_MAX/INT_MIN constants, and the stage-1 struct typedef.
REQ-032 SHALL put the stage-2 shift/round/saturate arithmetic in sub-module ftoi_round (combinational), with pipeline control in ftoi.

Verification
REQ-033 SHALL verify: s=0x3FC00000 (1.5) -> d=0x00000002; s=0xBFC00000 -> 0xFFFFFFFE; both ovf=0.
REQ-034 SHALL verify: s=0x40200000 (2.5) -> d=0x00000003 with TIE_AWAY=1, and 0x00000002 with TIE_AWAY=0; s=0x3EFFFFFF -> 0.
REQ-035 SHALL verify: s=0x4F000000 -> 0x7FFFFFFF, ovf=1; s=0xCF000000 -> 0x80000000, ovf=0; s=0x7FC00000 -> 0x7FFFFFFF, ovf=1.
REQ-036 SHALL verify: stream 8 words with d_ready toggling randomly -> outputs in order, no loss, d stable while stalled, s_ready=0 only when both stages full and d_ready=0.
REQ-037 SHALL verify: continuous input with d_ready=1 -> one result per cycle, first at 2 cycles after first acceptance.
REQ-038 SHALL verify: rst pulsed with 2 words in flight -> d_valid=0 immediately, no stale output after release, s_ready=1 next cycle.
